// File: rtl/hps_dot_sequencer_if.sv
// Bundle of the signals hps_dot_sequencer uses to talk to its neighbours:
// the operand stream in, the packed-word link to the multiplier, and the
// vector result out.
// The master side is whoever feeds operands, plays the multiplier and
// consumes results. The slave side is the sequencer itself.
interface hps_dot_sequencer_if #(
  parameter int ACC_W = 24
);
  logic [1:0]       cfg_mode;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             in_last;
  logic [7:0]       mul_x;
  logic [7:0]       mul_y;
  logic [1:0]       mul_mode;
  logic             mul_issue;
  logic [15:0]      mul_res;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_err;

  modport master (
    output cfg_mode, in_valid, in_a, in_b, in_last, mul_res, out_ready,
    input  in_ready, mul_x, mul_y, mul_mode, mul_issue, out_valid, out_sum, out_err
  );

  modport slave (
    input  cfg_mode, in_valid, in_a, in_b, in_last, mul_res, out_ready,
    output in_ready, mul_x, mul_y, mul_mode, mul_issue, out_valid, out_sum, out_err
  );
endinterface

// File: rtl/hps_dot_sequencer.sv
// Issue-side controller for a precision-scalable unsigned multiplier.
// Operand pairs are packed into x/y lanes, one group per issued word. The
// aligned dot-product results are accumulated over a vector. The vector sum
// is returned through a valid/ready port.
// MUL_LAT must be at least 2.
module hps_dot_sequencer #(
  parameter int ACC_W   = 24,
  parameter int MUL_LAT = 2
) (
  input logic                clk,
  input logic                rst,
  hps_dot_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FILL  = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [MUL_LAT-1:0] TAIL_MASK = MUL_LAT'(1) << (MUL_LAT - 1);

  state_t               state_r;
  state_t               state_next_s;
  logic                 in_ready_r;
  logic                 out_valid_r;
  logic                 out_err_r;
  logic [1:0]           mode_r;
  logic [1:0]           k_r;
  logic [7:0]           pack_x_r;
  logic [7:0]           pack_y_r;
  logic [7:0]           mul_x_r;
  logic [7:0]           mul_y_r;
  logic                 mul_issue_r;
  logic [MUL_LAT-1:0]   issue_pipe_r;
  logic [ACC_W-1:0]     acc_r;

  logic                 beat_s;
  logic [1:0]           beat_mode_s;
  logic [15:0]          slice_s;
  logic                 group_close_s;
  logic                 drain_done_s;
  logic [15:0]          res_aligned_s;

  // Places one operand pair into its lane slot for element k; returns {x, y}.
  function automatic logic [15:0] lane_pack(input logic [1:0] mode, input logic [1:0] k,
                                            input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x;
    logic [7:0] y;
    x = 8'd0;
    y = 8'd0;
    case (mode)
      2'b00: begin
        x = {6'd0, a[1:0]} << (3'd6 - {k, 1'b0});
        y = {6'd0, b[1:0]} << {k, 1'b0};
      end
      2'b10: begin
        if (k[0]) begin
          x = {4'd0, a[3:0]};
          y = {b[3:0], 4'd0};
        end else begin
          x = {a[3:0], 4'd0};
          y = {4'd0, b[3:0]};
        end
      end
      default: begin
        x = a;
        y = b;
      end
    endcase
    return {x, y};
  endfunction

  // Index of the last element in a group, i.e. group size minus one.
  function automatic logic [1:0] last_index(input logic [1:0] mode);
    case (mode)
      2'b00:   return 2'd3;
      2'b10:   return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  // Alignment shift the multiplier applies to its diagonal sum.
  function automatic logic [3:0] align_shift(input logic [1:0] mode);
    case (mode)
      2'b00:   return 4'd6;
      2'b10:   return 4'd4;
      default: return 4'd0;
    endcase
  endfunction

  // The first beat of a vector uses the live cfg_mode. Later beats use the latched mode.
  assign beat_s        = bus.in_valid & in_ready_r;
  assign beat_mode_s   = (state_r == IDLE) ? bus.cfg_mode : mode_r;
  assign slice_s       = lane_pack(beat_mode_s, k_r, bus.in_a, bus.in_b);
  assign group_close_s = bus.in_last | (k_r == last_index(beat_mode_s));
  // The final result is on mul_res when only the pipe tail is still set.
  assign drain_done_s  = !mul_issue_r && ((issue_pipe_r & ~TAIL_MASK) == {MUL_LAT{1'b0}});
  assign res_aligned_s = bus.mul_res >> align_shift(mode_r);

  assign bus.in_ready  = in_ready_r;
  assign bus.mul_x     = mul_x_r;
  assign bus.mul_y     = mul_y_r;
  assign bus.mul_mode  = mode_r;
  assign bus.mul_issue = mul_issue_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sum   = acc_r;
  assign bus.out_err   = out_err_r;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (beat_s) begin
          state_next_s = bus.in_last ? DRAIN : FILL;
        end else begin
          state_next_s = IDLE;
        end
      end
      FILL: begin
        if (beat_s && bus.in_last) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = FILL;
        end
      end
      DRAIN: begin
        if (drain_done_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = DRAIN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_err_r   <= 1'b0;
    end else begin
      in_ready_r  <= (state_next_s == IDLE) || (state_next_s == FILL);
      out_valid_r <= (state_next_s == DONE);
      out_err_r   <= (state_next_s == DONE) && (mode_r == 2'b01);
    end
  end

  // Latch the vector mode and build up the current group's packed word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r   <= 2'b00;
      k_r      <= 2'd0;
      pack_x_r <= 8'd0;
      pack_y_r <= 8'd0;
    end else if (beat_s) begin
      if (state_r == IDLE) begin
        mode_r <= bus.cfg_mode;
      end else begin
        mode_r <= mode_r;
      end
      if (group_close_s) begin
        k_r      <= 2'd0;
        pack_x_r <= 8'd0;
        pack_y_r <= 8'd0;
      end else begin
        k_r      <= k_r + 2'd1;
        pack_x_r <= pack_x_r | slice_s[15:8];
        pack_y_r <= pack_y_r | slice_s[7:0];
      end
    end else begin
      k_r      <= k_r;
      pack_x_r <= pack_x_r;
      pack_y_r <= pack_y_r;
    end
  end

  // Present a closed group to the multiplier for exactly one cycle; lanes idle at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_x_r     <= 8'd0;
      mul_y_r     <= 8'd0;
      mul_issue_r <= 1'b0;
    end else if (beat_s && group_close_s) begin
      mul_x_r     <= pack_x_r | slice_s[15:8];
      mul_y_r     <= pack_y_r | slice_s[7:0];
      mul_issue_r <= 1'b1;
    end else begin
      mul_x_r     <= 8'd0;
      mul_y_r     <= 8'd0;
      mul_issue_r <= 1'b0;
    end
  end

  // Track in-flight groups so results are taken exactly MUL_LAT cycles after issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_pipe_r <= {MUL_LAT{1'b0}};
    end else begin
      issue_pipe_r <= {issue_pipe_r[MUL_LAT-2:0], mul_issue_r};
    end
  end

  // Accumulate aligned results; the reserved mode never contributes to the sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= {ACC_W{1'b0}};
    end else if ((state_r == DONE) && bus.out_ready) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (issue_pipe_r[MUL_LAT-1] && (mode_r != 2'b01)) begin
      acc_r <= acc_r + ACC_W'(res_aligned_s);
    end else begin
      acc_r <= acc_r;
    end
  end

endmodule

// File: doc/hps_dot_sequencer.md
Name: hps_dot_sequencer

Overview:
- Issue-side controller for the precision-scalable unsigned multiplier (4x2b / 2x4b / 1x8b).
- Accepts a stream of narrow (a,b) operand pairs, packs them into the multiplier's x/y lane layout and issues one packed word per group.
- Captures the returned 16-bit dot-product word, removes the mode-dependent alignment shift and accumulates across the vector.
- Returns the vector's sum through a valid/ready output.

Parameters:
- ACC_W, 24, accumulator and out_sum width.
- MUL_LAT, 2, cycles from mul_issue-high cycle to the cycle mul_res is valid.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cfg_mode  input  2  00=2b, 10=4b, 11=8b, 01=reserved; sampled on first beat of a vector.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  beat accepted when in_valid&&in_ready.
- in_a  input  8  operand a; only low 2/4/8 bits used per mode.
- in_b  input  8  operand b; only low 2/4/8 bits used per mode.
- in_last  input  1  final beat of vector.
- mul_x  output  8  packed x to multiplier.
- mul_y  output  8  packed y to multiplier.
- mul_mode  output  2  latched mode to multiplier.
- mul_issue  output  1  high in cycles where mul_x/mul_y carry a group.
- mul_res  input  16  multiplier result word.
- out_valid  output  1  vector result valid.
- out_ready  input  1  consumer accept.
- out_sum  output  ACC_W  accumulated dot product.
- out_err  output  1  vector ran in reserved mode.

Behaviour:
- Reset (async): all outputs 0, state IDLE, acc=0, pack regs=0, issue pipe cleared; takes effect immediately mid-operation; results returning afterwards are ignored.
- States:
  - IDLE: in_ready=1; first accepted beat latches cfg_mode into mul_mode, moves to FILL, or DRAIN if in_last.
  - FILL: in_ready=1.
  - DRAIN: in_ready=0; waits until the issue pipe is empty and the last result is accumulated, then DONE.
  - DONE: out_valid=1, out_sum=acc, in_ready=0; on out_ready, acc cleared, back to IDLE next cycle.
- Group size G: 4 (mode 00), 2 (10), 1 (11 and 01). Element index k counts within the group.
- Packing, mode 00, k=0..3 (a/b = 2b each):
  - x slice: x[7:6], x[5:4], x[3:2], x[1:0].
  - y slice: y[1:0], y[3:2], y[5:4], y[7:6].
- Packing, mode 10, k=0..1 (4b each):
  - x slice: x[7:4], x[3:0].
  - y slice: y[3:0], y[7:4].
- Packing, modes 11/01: x=a, y=b.
- Group close:
  - A group closes when k reaches G-1 or on in_last; unfilled slices stay 0 (zero padding).
  - At the closing edge mul_x/mul_y load the packed word and mul_issue=1 for the following cycle; the pack register clears on that same edge.
  - Back-to-back groups are allowed, one per cycle in 8b mode.
  - When mul_issue=0, mul_x=mul_y=0.
- Issue pipe: a MUL_LAT-deep shift of mul_issue. When the tail is set, acc += mul_res >> S, with S=6 (00), 4 (10), 0 (11/01).
- Acc wraps modulo 2^ACC_W; there is no overflow flag.
- Latency: last beat accepted in cycle c -> mul_issue in c+1 -> mul_res valid in c+3 -> out_valid in c+4.
- out_valid/out_sum stay stable until the handshake.
- Reserved mode 01: beats are consumed and packed as 8b, but the multiplier returns 0; out_sum=0, out_err=1 alongside out_valid.
- cfg_mode changes mid-vector are ignored.

Test Plan:
- Mode 11: one beat a=255, b=255, last.
  -> mul_x=FF, mul_y=FF, mul_issue one cycle.
  -> out_valid 4 cycles after accept, out_sum=65025.
- Mode 10: beats (3,5), (7,2), last on second.
  -> mul_x=0x37, mul_y=0x25, mul_res=464.
  -> out_sum=29.
- Mode 00: five beats (3,3), last on fifth.
  -> issues x=FF/y=FF then x=C0/y=03.
  -> out_sum=45.
- Backpressure: hold out_ready=0 for 3 cycles in DONE.
  -> out_valid, out_sum stable; in_ready=0.
  -> after handshake a new 8b vector (2,3) yields out_sum=6 (acc cleared).
- Reset: assert rst in DRAIN with a result still in flight.
  -> all outputs 0 same cycle.
  -> following vector (1,1) in mode 11 gives out_sum=1.
- Mode 01: beats (9,9), (1,1).
  -> out_sum=0, out_err=1, then IDLE.
